// File: rtl/ai_host_if.sv
// Bus between the targeting host and the AI solver slave.
// The host drives writes and the slave answers with wait_request and rdata.
interface ai_host_if;
  logic [1:0]   ai_addr;
  logic         ai_write_en;
  logic [127:0] ai_wdata;
  logic         ai_wait_request;
  logic [127:0] ai_rdata;

  modport master (
    output ai_addr,
    output ai_write_en,
    output ai_wdata,
    input  ai_wait_request,
    input  ai_rdata
  );

  modport slave (
    input  ai_addr,
    input  ai_write_en,
    input  ai_wdata,
    output ai_wait_request,
    output ai_rdata
  );
endinterface

// File: rtl/ai_host.sv
// Battleship targeting host: tracks the board, hands it to the AI slave,
// and falls back to a linear scan when the suggestion is unusable.
module ai_host (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       new_game,
  input  logic       res_valid,
  input  logic [6:0] res_index,
  input  logic       res_hit,
  input  logic       res_sunk,
  input  logic [2:0] res_ship,
  input  logic       req,
  output logic       busy,
  output logic       target_valid,
  output logic [6:0] target,
  output logic       timeout_err,
  ai_host_if.master  ai
);

  typedef enum logic [3:0] {
    IDLE,
    WR_FIRED,
    WR_HITS,
    WR_SHIPS,
    START,
    WAIT_ACK,
    WAIT_DONE,
    CHECK,
    SCAN
  } state_t;

  state_t       state;
  logic [99:0]  fired;
  logic [99:0]  hits;
  logic [4:0]   ships;
  logic [6:0]   result;
  logic [6:0]   scan_idx;
  logic [11:0]  wdog;

  logic [127:0] fired_x;
  logic [127:0] res_mask;
  logic [7:0]   ship_mask;
  logic         res_ok;
  logic         unused_ok;

  assign fired_x   = {28'b0, fired};
  assign res_mask  = 128'd1 << res_index;
  assign ship_mask = 8'd1 << res_ship;
  assign busy      = (state != IDLE);

  // Malformed shot reports are dropped whole, not partially applied.
  assign res_ok = res_valid
                && (res_index <= 7'd99)
                && (!res_sunk || (res_ship <= 3'd4));

  assign unused_ok = &{1'b0, ai.ai_rdata[127:7],
                       res_mask[127:100], ship_mask[7:5]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      fired          <= '0;
      hits           <= '0;
      ships          <= 5'b11111;
      result         <= '0;
      scan_idx       <= '0;
      wdog           <= '0;
      target_valid   <= 1'b0;
      target         <= '0;
      timeout_err    <= 1'b0;
      ai.ai_write_en <= 1'b0;
      ai.ai_addr     <= '0;
      ai.ai_wdata    <= '0;
    end else begin
      target_valid <= 1'b0;
      if (new_game) begin
        state          <= IDLE;
        fired          <= '0;
        hits           <= '0;
        ships          <= 5'b11111;
        wdog           <= '0;
        timeout_err    <= 1'b0;
        ai.ai_write_en <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (res_ok) begin
              fired <= fired | res_mask[99:0];
              if (res_sunk) begin
                ships <= ships & ~ship_mask[4:0];
                hits  <= '0;
              end else if (res_hit) begin
                hits <= hits | res_mask[99:0];
              end
            end
            if (req) state <= WR_FIRED;
          end
          WR_FIRED: begin
            ai.ai_write_en <= !ai.ai_wait_request;
            if (!ai.ai_wait_request) begin
              ai.ai_addr  <= 2'd1;
              ai.ai_wdata <= {28'b0, fired};
              state       <= WR_HITS;
            end
          end
          WR_HITS: begin
            ai.ai_write_en <= !ai.ai_wait_request;
            if (!ai.ai_wait_request) begin
              ai.ai_addr  <= 2'd2;
              ai.ai_wdata <= {28'b0, hits};
              state       <= WR_SHIPS;
            end
          end
          WR_SHIPS: begin
            ai.ai_write_en <= !ai.ai_wait_request;
            if (!ai.ai_wait_request) begin
              ai.ai_addr  <= 2'd3;
              ai.ai_wdata <= {123'b0, ships};
              state       <= START;
            end
          end
          START: begin
            ai.ai_write_en <= !ai.ai_wait_request;
            if (!ai.ai_wait_request) begin
              ai.ai_addr  <= 2'd0;
              ai.ai_wdata <= '0;
              state       <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            ai.ai_write_en <= 1'b0;
            if (wdog == 12'hFFF) begin
              timeout_err  <= 1'b1;
              target_valid <= 1'b1;
              target       <= 7'd127;
              wdog         <= '0;
              state        <= IDLE;
            end else begin
              wdog <= wdog + 12'd1;
              if (ai.ai_wait_request) state <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (wdog == 12'hFFF) begin
              timeout_err  <= 1'b1;
              target_valid <= 1'b1;
              target       <= 7'd127;
              wdog         <= '0;
              state        <= IDLE;
            end else if (!ai.ai_wait_request) begin
              result <= ai.ai_rdata[6:0];
              wdog   <= '0;
              state  <= CHECK;
            end else begin
              wdog <= wdog + 12'd1;
            end
          end
          CHECK: begin
            if ((result <= 7'd99) && !fired_x[result]) begin
              target_valid <= 1'b1;
              target       <= result;
              state        <= IDLE;
            end else begin
              scan_idx <= '0;
              state    <= SCAN;
            end
          end
          SCAN: begin
            if (!fired_x[scan_idx]) begin
              target_valid <= 1'b1;
              target       <= scan_idx;
              state        <= IDLE;
            end else if (scan_idx == 7'd99) begin
              target_valid <= 1'b1;
              target       <= 7'd127;
              state        <= IDLE;
            end else begin
              scan_idx <= scan_idx + 7'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ai_host.sv
// Directed bench for ai_host with a behavioural AI slave
// and a target scoreboard.
module tb_ai_host;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       new_game = 1'b0;
  logic       res_valid = 1'b0;
  logic [6:0] res_index = '0;
  logic       res_hit = 1'b0;
  logic       res_sunk = 1'b0;
  logic [2:0] res_ship = '0;
  logic       req = 1'b0;
  logic       busy;
  logic       target_valid;
  logic [6:0] target;
  logic       timeout_err;

  ai_host_if ai ();

  ai_host dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .new_game     (new_game),
    .res_valid    (res_valid),
    .res_index    (res_index),
    .res_hit      (res_hit),
    .res_sunk     (res_sunk),
    .res_ship     (res_ship),
    .req          (req),
    .busy         (busy),
    .target_valid (target_valid),
    .target       (target),
    .timeout_err  (timeout_err),
    .ai           (ai)
  );

  always #5 clock = ~clock;

  // Slave: starts computing on a start write, answers after a few cycles.
  logic         init_hold = 1'b1;
  logic         hang = 1'b0;
  logic         comp = 1'b0;
  logic [2:0]   cnt = '0;
  logic [6:0]   model_res = '0;
  logic [127:0] rdata_q = '0;

  assign ai.ai_wait_request = init_hold | comp;
  assign ai.ai_rdata        = rdata_q;

  always @(posedge clock) begin
    if (ai.ai_write_en === 1'b1 && ai.ai_addr == 2'd0) begin
      comp <= 1'b1;
      cnt  <= 3'd3;
    end else if (comp && !hang) begin
      if (cnt == 3'd0) begin
        comp    <= 1'b0;
        rdata_q <= {121'b0, model_res};
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int tv_count = 0;
  int tv_cyc = 0;
  int we_bad = 0;
  logic [6:0]   sb[$];
  int           wl_addr[$];
  int           wl_cyc[$];
  logic [127:0] last_w[4];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    logic [6:0] e;
    #2;
    if (ai.ai_write_en === 1'b1) begin
      if (init_hold) we_bad++;
      wl_addr.push_back(int'(ai.ai_addr));
      wl_cyc.push_back(cyc);
      last_w[ai.ai_addr] = ai.ai_wdata;
    end
    if (target_valid === 1'b1) begin
      tv_count++;
      tv_cyc = cyc;
      chk("sb_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("target", target, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic shot(input int idx, input logic h,
                      input logic s, input int sh);
    res_valid = 1'b1;
    res_index = idx[6:0];
    res_hit   = h;
    res_sunk  = s;
    res_ship  = sh[2:0];
    @(negedge clock);
    res_valid = 1'b0;
    res_hit   = 1'b0;
    res_sunk  = 1'b0;
  endtask

  task automatic request(input logic [6:0] m, output int t0);
    model_res = m;
    req = 1'b1;
    t0 = cyc;
    @(negedge clock);
    req = 1'b0;
  endtask

  task automatic pulse_ng();
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
  endtask

  task automatic wait_tv(input int n0, input int lim);
    int k = 0;
    while (tv_count == n0 && k < lim) begin
      @(negedge clock);
      k++;
    end
    chk("tv_arrived", tv_count - n0, 1);
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_cyc.delete();
    for (int i = 0; i < 4; i++) last_w[i] = 'x;
  endtask

  initial begin
    int t0;
    int n0;
    int lat_ref;
    int exp_a[4];
    logic [127:0] e;

    exp_a[0] = 1;
    exp_a[1] = 2;
    exp_a[2] = 3;
    exp_a[3] = 0;
    clear_log();

    // Reset values
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_tv", target_valid, 0);
    chk("rst_target", target, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_we", ai.ai_write_en, 0);
    chk("rst_addr", ai.ai_addr, 0);
    chk("rst_wdata", ai.ai_wdata, 0);
    reset_n = 1'b1;
    tick(1);

    // First request stalls behind the slave's initial wait_request
    n0 = tv_count;
    sb.push_back(7'd50);
    request(7'd50, t0);
    tick(19);
    chk("init_busy", busy, 1);
    chk("init_no_write", wl_addr.size(), 0);
    init_hold = 1'b0;
    wait_tv(n0, 100);
    chk("init_we_bad", we_bad, 0);
    chk("init_nwrites", wl_addr.size(), 4);
    if (wl_addr.size() == 4) begin
      for (int i = 0; i < 4; i++)
        chk("init_addr_seq", wl_addr[i], exp_a[i]);
      for (int i = 1; i < 4; i++)
        chk("init_consec", wl_cyc[i] - wl_cyc[i-1], 1);
    end
    chk("init_w_fired", last_w[1], 0);
    chk("init_w_hits", last_w[2], 0);
    chk("init_w_ships", last_w[3], 128'h1f);
    chk("init_w_start", last_w[0], 0);
    chk("idle_busy", busy, 0);

    // Hit at 23, AI suggests 24
    pulse_ng();
    shot(23, 1'b1, 1'b0, 0);
    clear_log();
    n0 = tv_count;
    sb.push_back(7'd24);
    request(7'd24, t0);
    wait_tv(n0, 100);
    lat_ref = tv_cyc - t0;
    e = '0;
    e[23] = 1'b1;
    chk("hit_w_fired", last_w[1], e);
    chk("hit_w_hits", last_w[2], e);
    tick(3);
    chk("target_hold", target, 24);

    // Sink ship 2 coincident with req; malformed reports dropped
    shot(24, 1'b1, 1'b0, 0);
    shot(100, 1'b1, 1'b0, 0);
    shot(30, 1'b1, 1'b1, 5);
    clear_log();
    n0 = tv_count;
    sb.push_back(7'd60);
    model_res = 7'd60;
    res_valid = 1'b1;
    res_index = 7'd25;
    res_hit   = 1'b1;
    res_sunk  = 1'b1;
    res_ship  = 3'd2;
    req = 1'b1;
    @(negedge clock);
    res_valid = 1'b0;
    res_hit   = 1'b0;
    res_sunk  = 1'b0;
    req = 1'b0;
    wait_tv(n0, 100);
    e = '0;
    e[23] = 1'b1;
    e[24] = 1'b1;
    e[25] = 1'b1;
    chk("sunk_w_fired", last_w[1], e);
    chk("sunk_w_hits", last_w[2], 0);
    chk("sunk_w_ships", last_w[3], 128'b11011);

    // Already-fired suggestion forces a scan
    pulse_ng();
    for (int i = 0; i < 5; i++) shot(i, 1'b0, 1'b0, 0);
    shot(23, 1'b0, 1'b0, 0);
    n0 = tv_count;
    sb.push_back(7'd5);
    request(7'd23, t0);
    wait_tv(n0, 100);
    chk("scan_latency", tv_cyc - t0, lat_ref + 6);
    n0 = tv_count;
    sb.push_back(7'd5);
    request(7'd110, t0);
    wait_tv(n0, 100);
    chk("scan_oob_latency", tv_cyc - t0, lat_ref + 6);

    // Board full: scan gives up with 127
    pulse_ng();
    for (int i = 0; i < 100; i++) shot(i, 1'b0, 1'b0, 0);
    n0 = tv_count;
    sb.push_back(7'd127);
    request(7'd7, t0);
    wait_tv(n0, 300);

    // Slave never finishes: watchdog
    pulse_ng();
    hang = 1'b1;
    n0 = tv_count;
    sb.push_back(7'd127);
    request(7'd9, t0);
    wait_tv(n0, 5000);
    chk("wdog_flag", timeout_err, 1);
    chk("wdog_min_wait", (tv_cyc - t0) >= 4095, 1);
    hang = 1'b0;
    tick(10);
    chk("wdog_sticky", timeout_err, 1);
    pulse_ng();
    chk("wdog_clear", timeout_err, 0);

    // new_game during WAIT_DONE aborts the request
    clear_log();
    model_res = 7'd40;
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    begin
      int k = 0;
      while (wl_addr.size() < 4 && k < 50) begin
        @(negedge clock);
        k++;
      end
    end
    chk("abort_nwrites", wl_addr.size(), 4);
    tick(2);
    chk("abort_busy_before", busy, 1);
    n0 = tv_count;
    new_game  = 1'b1;
    res_valid = 1'b1;
    res_index = 7'd10;
    res_hit   = 1'b1;
    @(negedge clock);
    new_game  = 1'b0;
    res_valid = 1'b0;
    res_hit   = 1'b0;
    chk("abort_idle", busy, 0);
    tick(10);
    chk("abort_no_tv", tv_count - n0, 0);
    clear_log();
    n0 = tv_count;
    sb.push_back(7'd10);
    request(7'd10, t0);
    wait_tv(n0, 100);
    chk("abort_w_fired", last_w[1], 0);
    chk("abort_w_hits", last_w[2], 0);

    tick(5);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ai_host.md
AI_HOST -- requirements
Module: ai_host

Interface
REQ-001 SHALL have ports, clock and reset first: clock  input  1  system clock; reset_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have: new_game  in  1  one-cycle pulse, clear board state.
REQ-003 SHALL have: res_valid  in  1  shot-result strobe; res_index  in  7  cell 0..99 (row*10+col); res_hit  in  1  shot hit; res_sunk  in  1  shot sank a ship; res_ship  in  3  sunk ship id 0..4.
REQ-004 SHALL have: req  in  1  request next target; busy  out  1  request in progress; target_valid  out  1  one-cycle pulse; target  out  7  chosen cell; timeout_err  out  1  sticky watchdog flag.
REQ-005 SHALL have the AI slave master port: ai_addr  out  2  (0 start, 1 fired, 2 hits, 3 ships); ai_write_en  out  1; ai_wdata  out  128  zero-padded payload; ai_wait_request  in  1; ai_rdata  in  128  result, bits [6:0].

Function
REQ-006 SHALL hold board registers fired[99:0], hits[99:0], ships[4:0].
REQ-007 res_valid in IDLE SHALL set fired[res_index]; if res_hit also set hits[res_index]; if res_sunk clear ships[res_ship] and clear all of hits.
REQ-008 res_valid with res_index > 99 or res_ship > 4 (when res_sunk) SHALL be ignored entirely; res_valid outside IDLE SHALL be ignored.
REQ-009 new_game in any state SHALL clear fired and hits, set ships = 5'b11111, deassert ai_write_en, and return to IDLE next cycle; it takes priority over res_valid and req.
REQ-010 FSM states: IDLE, WR_FIRED, WR_HITS, WR_SHIPS, START, WAIT_ACK, WAIT_DONE, CHECK, SCAN.
REQ-011 req in IDLE SHALL move to WR_FIRED; if res_valid and req coincide, the board update applies first and the request uses the updated board.
REQ-012 WR_FIRED/WR_HITS/WR_SHIPS/START SHALL each drive ai_write_en=1 for exactly one cycle with ai_addr 1/2/3/0 and ai_wdata = {28'b0,fired} / {28'b0,hits} / {123'b0,ships} / 0, issued only in a cycle where ai_wait_request=0; otherwise ai_write_en=0 and the state holds.
REQ-013 WAIT_ACK SHALL wait for ai_wait_request=1 (slave acknowledges start), then WAIT_DONE SHALL wait for ai_wait_request=0, then sample ai_rdata[6:0] into a result register and go to CHECK.
REQ-014 CHECK: result <= 99 and fired[result]=0 SHALL pulse target_valid with target=result next cycle, return to IDLE.
REQ-015 CHECK: otherwise SHALL enter SCAN, testing one cell per cycle from index 0 upward; first cell with fired=0 SHALL be emitted via target_valid; if all 100 cells fired, emit target=7'd127.
REQ-016 busy SHALL be 1 in every state except IDLE; req while busy SHALL be ignored (no queueing).
REQ-017 A 12-bit watchdog SHALL count cycles spent in WAIT_ACK plus WAIT_DONE; on reaching 4095 SHALL set timeout_err, emit target_valid with target=7'd127, return to IDLE; counter clears on leaving those states.
REQ-018 timeout_err SHALL clear only on new_game or reset.
REQ-019 target SHALL hold its last value between pulses.

Reset
REQ-020 reset_n low SHALL immediately force IDLE, fired=0, hits=0, ships=5'b11111, busy=0, target_valid=0, target=0, timeout_err=0, ai_write_en=0, ai_addr=0, ai_wdata=0, watchdog=0.
REQ-021 After reset, the first write SHALL wait for ai_wait_request=0 (slave initialises with it high).

Verification
REQ-022 Reset, slave model holds wait_request high 20 cycles, req -> no ai_write_en until wait_request low; then addr 1,2,3,0 writes on consecutive cycles.
REQ-023 res_valid index 23 hit=1, then req, model returns 24 -> ai_wdata fired bit 23 and hits bit 23 set; target_valid with target=24.
REQ-024 res_sunk ship 2 after hits at 23,24 -> ships write = 5'b11011, hits write = 0.
REQ-025 Model returns 23 (already fired) with fired[0..4]=1 -> SCAN, target=5 after 6 scan cycles.
REQ-026 Model never deasserts wait_request after start -> timeout_err=1 and target=127 after 4095 cycles; new_game clears flag.
REQ-027 new_game asserted during WAIT_DONE -> IDLE next cycle, board cleared, no target_valid; following req completes normally.
